geg_core: RTL and testbench
===========================

// Module: geg_core
// PURPOSE
//  Minimal RV32I integer core with instruction-fetch read channel only (no data port).
//  - Issues word addresses on RCH1_ADDR; the memory returns the word one clock later
//    on RCH1_DATA (synchronous read, registered).
//  - Executes the ALU, jump and branch subset in a 2-stage fetch/execute pipeline.
//  - Top-level compute block of the system; memory and stall source are external.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset
// PORTS
//  CLK         in   1   single clock, rising edge
//  RSTN        in   1   asynchronous, active-low reset
//  CORE_STALL  in   1   1 = freeze pipeline and architectural state
//  RCH1_ADDR   out  32  byte address of instruction fetch; bits[1:0] always 0
//  RCH1_DATA   in   32  instruction word for address sampled at previous rising edge
// BEHAVIOUR
//  State: pc_f (next fetch addr), pc_m (addr whose data is on RCH1_DATA), valid_m,
//   x1..x31 (x0 reads 0, writes ignored).
//  Reset (RSTN=0, async):
//   - pc_f=RESET_PC, pc_m=RESET_PC, valid_m=0, all regs 0.
//   - RCH1_ADDR=RESET_PC. No fetch advance while RSTN=0.
//  RCH1_ADDR = CORE_STALL ? pc_m : pc_f (combinational mux).
//   - Memory re-reads pc_m during a stall, so RCH1_DATA still holds that word on release.
//  Normal edge (CORE_STALL=0):
//   - pc_m<=pc_f; valid_m<=1; pc_f<=pc_f+4 (wraps mod 2^32).
//   - If valid_m: execute RCH1_DATA at pc_m combinationally and commit rd at this edge.
//  Redirect (taken branch, JAL, JALR while valid_m):
//   - pc_f<=target, valid_m<=0 (kills wrong-path word pc_m+4). Exactly 1 bubble.
//   - JAL/JALR write rd=pc_m+4.
//  Stall edge (CORE_STALL=1): all state holds; no execution, no regfile write.
//   Stall + redirect pending: redirect deferred until stall drops.
//  Supported ops:
//   - LUI, AUIPC.
//   - OP-IMM: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
//   - OP: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
//   - JAL, JALR (target=(rs1+imm)&~1).
//   - BEQ BNE BLT BGE BLTU BGEU (target=pc_m+imm).
//  Arithmetic: 32-bit, wrap-around, no flags. Shift amount = low 5 bits.
//  Target bits[1:0] forced to 0; no misalignment exception.
//  LOAD, STORE, FENCE, SYSTEM and any illegal/unknown encoding (incl. 0x00000000):
//   NOP, sequential flow, no trap.
//  Reads of rs1/rs2 see values committed at earlier edges (single issue, no hazard).
// STRUCTURE
//  - Package core_pkg: opcode localparams (OP_LUI..OP_SYSTEM), funct3 codes,
//    alu_op_e enum, imm-type enum.
//  - Sub-module core_regfile: 31x32 regs, 2 async read ports, 1 sync write port,
//    async reset, x0 hardwired.
//  - Top: fetch regs, decoder, ALU, branch compare, next-PC mux.
// TESTING
//  1. RSTN low 3 cycles then high, MEM=NOPs -> RCH1_ADDR 0,4,8,12 on successive edges.
//  2. MEM[0]=0x010000EF (JAL x1,+16) -> addr seq 0,4,16,20; x1=4.
//  3. MEM[0]=0x04000113 (ADDI x2,x0,0x40), MEM[1]=0x00010067 (JALR x0,0(x2))
//     -> seq 0,4,8,0x40,0x44; x2=0x40.
//  4. MEM[0]=0x00000663 (BEQ x0,x0,+12) -> seq 0,4,12.
//     With 0x00001663 (BNE), not taken -> 0,4,8.
//  5. CORE_STALL high 3 cycles mid-stream -> RCH1_ADDR=pc_m, regs frozen;
//     after release no instruction skipped or duplicated.
//  6. MEM=0x00000000 and LOAD/STORE words -> treated as NOP, sequential fetch,
//     regfile unchanged.
//  7. RSTN low mid-run after JAL -> immediate RCH1_ADDR=0, x1 cleared.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I encodings, ALU operation set and immediate decoding helpers.
// Used by the fetch/execute top; no state lives here.
// Opcodes outside the listed set decode as NOP in the core.
package core_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {IMM_I, IMM_U, IMM_J, IMM_B} imm_type_e;

  function automatic logic [31:0] imm_gen(imm_type_e t, logic [31:0] ins);
    case (t)
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_B:   return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      default: return {{20{ins[31]}}, ins[31:20]};
    endcase
  endfunction

  function automatic logic [31:0] alu(alu_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << b[4:0];
      ALU_SLT:   return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  return {31'b0, a < b};
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      default:   return b;
    endcase
  endfunction

endpackage

// File: rtl/geg_core_if.sv
// Instruction-fetch read channel: address out, registered data back next clock.
// Latency: data for an address appears one rising edge after it is presented.
// No handshake; the core holds the address steady while stalled.
interface geg_core_if;
  logic [31:0] RCH1_ADDR;
  logic [31:0] RCH1_DATA;

  modport master (output RCH1_ADDR, input RCH1_DATA);
  modport slave  (input RCH1_ADDR, output RCH1_DATA);
endinterface

// File: rtl/core_regfile.sv
// x1..x31 integer registers, two combinational read ports, one write port.
// Latency: writes visible to reads after the committing edge.
// No backpressure; the caller gates the write enable.
module core_regfile (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs_q [1:31];

  // register array; writes to x0 are dropped since it has no storage
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/geg_core.sv
// Two-stage RV32I core (fetch / execute) covering ALU, jump and branch ops.
// Latency: one instruction per clock; a taken redirect costs one bubble.
// CORE_STALL freezes all state and re-presents the in-flight fetch address.
module geg_core
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CORE_STALL,
  geg_core_if.master    rch1
);

  logic [31:0] pc_f_q, pc_f_d, pc_m_q, pc_m_d;
  logic        valid_m_q, valid_m_d;

  logic [31:0] ins;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_u, imm_j, imm_b;

  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [31:0] target, wb_val;
  logic        wr_en, link, redirect, exec;

  assign ins    = rch1.RCH1_DATA;
  assign opcode = ins[6:0];
  assign rd     = ins[11:7];
  assign f3     = ins[14:12];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign f7     = ins[31:25];

  assign imm_i = imm_gen(IMM_I, ins);
  assign imm_u = imm_gen(IMM_U, ins);
  assign imm_j = imm_gen(IMM_J, ins);
  assign imm_b = imm_gen(IMM_B, ins);

  // During a stall the memory re-reads pc_m so its word is still valid on release
  assign rch1.RCH1_ADDR = CORE_STALL ? pc_m_q : pc_f_q;

  assign exec = valid_m_q && !CORE_STALL;

  core_regfile u_rf (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .we_i  (exec && wr_en),
    .wa_i  (rd),
    .wd_i  (wb_val),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rs1_val),
    .rd2_o (rs2_val)
  );

  // decode: ALU operands, writeback enable and redirect target; unknown encodings stay NOP
  always_comb begin
    alu_op   = ALU_ADD;
    alu_a    = rs1_val;
    alu_b    = rs2_val;
    wr_en    = 1'b0;
    link     = 1'b0;
    redirect = 1'b0;
    target   = pc_m_q + imm_b;
    case (opcode)
      OP_LUI: begin
        wr_en  = 1'b1;
        alu_op = ALU_PASSB;
        alu_b  = imm_u;
      end
      OP_AUIPC: begin
        wr_en = 1'b1;
        alu_a = pc_m_q;
        alu_b = imm_u;
      end
      OP_IMM, OP_OP: begin
        wr_en = 1'b1;
        if (opcode == OP_IMM) alu_b = imm_i;
        case (f3)
          F3_ADD: begin
            if (opcode == OP_OP && f7 == F7_ALT) alu_op = ALU_SUB;
            else if (opcode == OP_OP && f7 != F7_ZERO) wr_en = 1'b0;
          end
          F3_SR: begin
            if (f7 == F7_ALT) alu_op = ALU_SRA;
            else if (f7 == F7_ZERO) alu_op = ALU_SRL;
            else wr_en = 1'b0;
          end
          default: begin
            case (f3)
              F3_SLL:  alu_op = ALU_SLL;
              F3_SLT:  alu_op = ALU_SLT;
              F3_SLTU: alu_op = ALU_SLTU;
              F3_XOR:  alu_op = ALU_XOR;
              F3_OR:   alu_op = ALU_OR;
              default: alu_op = ALU_AND;
            endcase
            // immediate forms other than SLLI carry no funct7 field
            if ((opcode == OP_OP || f3 == F3_SLL) && f7 != F7_ZERO) wr_en = 1'b0;
          end
        endcase
      end
      OP_JAL: begin
        wr_en    = 1'b1;
        link     = 1'b1;
        redirect = 1'b1;
        target   = pc_m_q + imm_j;
      end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          wr_en    = 1'b1;
          link     = 1'b1;
          redirect = 1'b1;
          target   = rs1_val + imm_i;
        end
      end
      OP_BRANCH: begin
        case (f3)
          F3_BEQ:  redirect = (rs1_val == rs2_val);
          F3_BNE:  redirect = (rs1_val != rs2_val);
          F3_BLT:  redirect = ($signed(rs1_val) <  $signed(rs2_val));
          F3_BGE:  redirect = ($signed(rs1_val) >= $signed(rs2_val));
          F3_BLTU: redirect = (rs1_val <  rs2_val);
          F3_BGEU: redirect = (rs1_val >= rs2_val);
          default: redirect = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign alu_res = alu(alu_op, alu_a, alu_b);
  assign wb_val  = link ? (pc_m_q + 32'd4) : alu_res;

  // next fetch state: advance, redirect (killing the wrong-path word), or hold on stall
  always_comb begin
    pc_f_d    = pc_f_q;
    pc_m_d    = pc_m_q;
    valid_m_d = valid_m_q;
    if (!CORE_STALL) begin
      pc_m_d = pc_f_q;
      if (exec && redirect) begin
        pc_f_d    = {target[31:2], 2'b00};
        valid_m_d = 1'b0;
      end else begin
        pc_f_d    = pc_f_q + 32'd4;
        valid_m_d = 1'b1;
      end
    end
  end

  // fetch-stage registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_f_q    <= RESET_PC;
      pc_m_q    <= RESET_PC;
      valid_m_q <= 1'b0;
    end else begin
      pc_f_q    <= pc_f_d;
      pc_m_q    <= pc_m_d;
      valid_m_q <= valid_m_d;
    end
  end

endmodule

// File: tb/tb_geg_core.sv
// Directed bench for geg_core: table of small programs with expected fetch
// address sequences and a final register value, plus hand-written stall and
// mid-run reset sequences.
module tb_geg_core;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK = 1'b0;
  logic RSTN = 1'b1;
  logic CORE_STALL = 1'b0;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  geg_core_if bus();

  geg_core dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .CORE_STALL (CORE_STALL),
    .rch1       (bus)
  );

  always #5 CLK = ~CLK;

  // registered instruction memory
  always @(posedge CLK) bus.RCH1_DATA <= mem[bus.RCH1_ADDR[7:2]];

  typedef struct {
    string            name;
    logic [3:0][31:0] w;
    int               n;
    logic [5:0][31:0] addr;
    int               ridx;
    logic [31:0]      rval;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rreg(int i);
    if (i == 0) return 32'd0;
    return dut.u_rf.regs_q[i];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  // hold reset 3 edges, checking reset state, then release just after an edge
  task automatic do_reset(input string nm);
    CORE_STALL = 1'b0;
    RSTN = 1'b1;
    #1;
    RSTN = 1'b0;
    #1;
    chk({nm, " rst addr"}, bus.RCH1_ADDR, 32'h0);
    chk({nm, " rst x1"}, rreg(1), 32'h0);
    repeat (3) tick();
    chk({nm, " rst hold addr"}, bus.RCH1_ADDR, 32'h0);
    RSTN = 1'b1;
  endtask

  task automatic add_vec(input string nm,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input int n,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
                         input int ridx, input logic [31:0] rval);
    vec_t v;
    v.name = nm;
    v.w = {w3, w2, w1, w0};
    v.n = n;
    v.addr = {a5, a4, a3, a2, a1, a0};
    v.ridx = ridx;
    v.rval = rval;
    vecs.push_back(v);
  endtask

  initial begin
    //       name     program words                                     n  fetch addresses                      reg  value
    add_vec("nop",   NOP,          NOP,          NOP,          NOP,          4, 0, 4, 8, 12, 0, 0,                  1, 32'h0);
    add_vec("jal",   32'h010000EF, NOP,          NOP,          NOP,          4, 0, 4, 16, 20, 0, 0,                 1, 32'h4);
    add_vec("jalr",  32'h04000113, 32'h00010067, NOP,          NOP,          5, 0, 4, 8, 32'h40, 32'h44, 0,         2, 32'h40);
    add_vec("beq",   32'h00000663, NOP,          NOP,          NOP,          4, 0, 4, 12, 16, 0, 0,                 1, 32'h0);
    add_vec("bne",   32'h00001663, NOP,          NOP,          NOP,          4, 0, 4, 8, 12, 0, 0,                  1, 32'h0);
    add_vec("blt",   32'hFFF00093, 32'h0000C663, NOP,          NOP,          5, 0, 4, 8, 16, 20, 0,                 1, 32'hFFFF_FFFF);
    add_vec("bltu",  32'hFFF00093, 32'h0000E663, NOP,          NOP,          5, 0, 4, 8, 12, 16, 0,                 1, 32'hFFFF_FFFF);
    add_vec("srai",  32'hFFB00093, 32'h4010D113, NOP,          NOP,          4, 0, 4, 8, 12, 0, 0,                  2, 32'hFFFF_FFFD);
    add_vec("sub",   32'h00300313, 32'h406003B3, NOP,          NOP,          4, 0, 4, 8, 12, 0, 0,                  7, 32'hFFFF_FFFD);
    add_vec("lui",   32'h123452B7, NOP,          NOP,          NOP,          3, 0, 4, 8, 0, 0, 0,                   5, 32'h1234_5000);
    add_vec("auipc", NOP,          32'h00001217, NOP,          NOP,          4, 0, 4, 8, 12, 0, 0,                  4, 32'h0000_1004);
    add_vec("nopop", 32'h00000000, 32'h00002083, 32'h00102023, 32'h0000000F, 5, 0, 4, 8, 12, 16, 0,                 1, 32'h0);

    foreach (vecs[vi]) begin
      load(vecs[vi].w[0], vecs[vi].w[1], vecs[vi].w[2], vecs[vi].w[3]);
      do_reset(vecs[vi].name);
      chk({vecs[vi].name, " addr0"}, bus.RCH1_ADDR, vecs[vi].addr[0]);
      for (int k = 1; k < vecs[vi].n; k++) begin
        tick();
        chk($sformatf("%s addr%0d", vecs[vi].name, k), bus.RCH1_ADDR, vecs[vi].addr[k]);
      end
      chk($sformatf("%s x%0d", vecs[vi].name, vecs[vi].ridx), rreg(vecs[vi].ridx), vecs[vi].rval);
    end

    // stall mid-stream: fetch address falls back to pc_m, counter register frozen
    load(32'h00100093, 32'h00108093, 32'h00108093, 32'h00108093);
    for (int i = 4; i < 8; i++) mem[i] = 32'h00108093;
    do_reset("stall");
    tick(); tick();
    chk("stall pre x1", rreg(1), 32'd1);
    CORE_STALL = 1'b1;
    #1;
    chk("stall addr", bus.RCH1_ADDR, 32'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall hold addr%0d", k), bus.RCH1_ADDR, 32'd4);
      chk($sformatf("stall hold x1_%0d", k), rreg(1), 32'd1);
    end
    CORE_STALL = 1'b0;
    #1;
    chk("stall release addr", bus.RCH1_ADDR, 32'd8);
    tick();
    chk("stall post addr1", bus.RCH1_ADDR, 32'd12);
    chk("stall post x1a", rreg(1), 32'd2);
    tick();
    chk("stall post addr2", bus.RCH1_ADDR, 32'd16);
    chk("stall post x1b", rreg(1), 32'd3);

    // stall while a JAL sits in execute: redirect deferred until release
    load(32'h010000EF, NOP, NOP, NOP);
    do_reset("stjal");
    tick();
    CORE_STALL = 1'b1;
    #1;
    chk("stjal addr", bus.RCH1_ADDR, 32'd0);
    tick(); tick();
    chk("stjal hold addr", bus.RCH1_ADDR, 32'd0);
    chk("stjal hold x1", rreg(1), 32'd0);
    CORE_STALL = 1'b0;
    #1;
    chk("stjal release addr", bus.RCH1_ADDR, 32'd4);
    tick();
    chk("stjal target", bus.RCH1_ADDR, 32'd16);
    chk("stjal x1", rreg(1), 32'd4);
    tick();
    chk("stjal next", bus.RCH1_ADDR, 32'd20);

    // asynchronous reset mid-run after a JAL
    load(32'h010000EF, NOP, NOP, NOP);
    do_reset("midrst");
    tick(); tick(); tick();
    chk("midrst pre addr", bus.RCH1_ADDR, 32'd20);
    chk("midrst pre x1", rreg(1), 32'd4);
    #2;
    RSTN = 1'b0;
    #1;
    chk("midrst addr", bus.RCH1_ADDR, 32'd0);
    chk("midrst x1", rreg(1), 32'd0);
    tick();
    chk("midrst hold", bus.RCH1_ADDR, 32'd0);
    RSTN = 1'b1;
    tick();
    chk("midrst resume", bus.RCH1_ADDR, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
